param_seq_detector: RTL and testbench
=====================================

# param_seq_detector

Parametrised, run-time programmable serial bit-pattern detector; the successor to the fixed 4-bit "1011" detector. It matches any pattern of 1 to MAX_LEN bits loaded at run time. Overlapping or non-overlapping detection is selectable, input is qualified by a valid strobe, and an optional saturating match counter is available. It sits on a serial input stream and flags each completed pattern to downstream control logic.

## Interface
- MAX_LEN, 8, maximum pattern length in bits; must be ≥2.
- CNT_W, 16, width of match_count.
- LEN_W, $clog2(MAX_LEN+1) (derived, do not override), width of pat_len.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_load  input  1  latches pattern, pat_len and overlap_en; clears the history.
- pattern  input  MAX_LEN  pattern bits; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  input  LEN_W  pattern length. 0 means disabled; values >MAX_LEN are clamped to MAX_LEN.
- overlap_en  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- in_valid  input  1  in_bit is sampled only when this is high.
- in_bit  input  1  serial data bit.
- armed  output  1  high while a valid configuration is held.
- seq_detected  output  1  registered one-cycle pulse per match.
- match_count  output  CNT_W  saturating count of matches (see Configuration).

## Operation
- Internal registers:
  - cfg_pat[MAX_LEN]: latched pattern.
  - cfg_len: latched length after clamping.
  - cfg_ovl: latched overlap mode.
  - hist[MAX_LEN]: shift register; newest bit at hist[0].
  - fill: number of valid history bits, 0..MAX_LEN, saturating.
- FSM with two states:
  - UNCFG (reset state): in_valid is ignored; seq_detected stays 0.
  - ARMED: detection active.
  - Any state with cfg_load and clamped length ≠0 → ARMED.
  - Any state with cfg_load and pat_len=0 → UNCFG.
  - No other transitions.
- cfg_load clears hist and fill to 0 and takes priority over an in_valid in the same cycle; that in_bit is discarded.
- In ARMED with in_valid=1:
  - hist ← {hist[MAX_LEN-2:0], in_bit}.
  - fill ← min(fill+1, MAX_LEN).
- Match is evaluated on the updated history: (fill_next ≥ cfg_len) and hist_next[cfg_len-1:0] == cfg_pat[cfg_len-1:0].
- On a match:
  - seq_detected=1 in the next cycle.
  - If cfg_ovl=0, fill ← 0, so no bit of a matched occurrence is reused. hist is not cleared.
  - If cfg_ovl=1, fill is updated normally.
- When in_valid=0, hist, fill and seq_detected are not updated, and seq_detected is 0.
- Pattern bits above cfg_len are ignored.

## Timing
- Reset values: armed=0, seq_detected=0, match_count=0, state UNCFG, hist=0, fill=0, cfg_len=0, cfg_pat=0, cfg_ovl=0.
- Latency: seq_detected is high in the cycle after the clk edge that samples the final pattern bit. It is high for exactly one cycle per match.
- Back-to-back matches give consecutive pulses, e.g. overlapping pattern "11" on an all-ones stream.
- armed updates the cycle after cfg_load.
- A reset asserted mid-stream clears everything asynchronously. After reset deassertion, cfg_load is required before detection resumes.
- pat_len=1 is legal: every bit equal to cfg_pat[0] produces a match.

## Configuration
- SEQDET_MATCH_COUNT_EN defined:
  - match_count increments by 1 per match, in the same cycle seq_detected asserts.
  - It saturates at 2^CNT_W−1.
  - cfg_load clears it to 0.
- Not defined: match_count is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- MAX_LEN=8, load pattern=8'b0000_1011, pat_len=4, overlap_en=1; stream 1,0,1,1,0,1,1 (in_valid=1) → seq_detected pulses the cycle after the 4th bit and the cycle after the 7th bit; match_count=2.
- Same stream with overlap_en=0 → single pulse after the 4th bit only; match_count=1.
- Pattern "11", pat_len=2, overlap_en=1; eight 1s → seven consecutive pulses. With overlap_en=0 → four pulses, after bits 2, 4, 6 and 8.
- Pattern "101"; stream 1,0 then in_valid=0 for 5 cycles, then 1 → one pulse after the final bit; no pulse during the gap.
- cfg_load with pat_len=0 → armed=0 and the stream produces no pulses. cfg_load with pat_len=12 on MAX_LEN=8 → length clamped to 8 and an 8-bit pattern matches. cfg_load coincident with in_valid → that bit is discarded.
- rst pulsed after 3 of 4 pattern bits → all outputs 0 immediately; following bits produce no match until cfg_load; counter saturates at 2^CNT_W−1 with CNT_W=2 after 4+ matches (SEQDET_MATCH_COUNT_EN defined).

Source files
------------

// File: rtl/param_seq_detector.sv
// Run-time programmable serial pattern detector (1..MAX_LEN bits).
// Optional saturating match counter: define SEQDET_MATCH_COUNT_EN.
module param_seq_detector #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               armed,
  output logic               seq_detected,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic {
    UNCFG,
    ARMED
  } state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               seq_q, seq_d;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_clamp;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;

  // Clamp requested length and build the compare mask from the held length
  always_comb begin
    len_clamp = pat_len;
    if (pat_len > LEN_W'(MAX_LEN)) begin
      len_clamp = LEN_W'(MAX_LEN);
    end
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    fill_inc = fill_q + 1'b1;
    if (fill_q == LEN_W'(MAX_LEN)) begin
      fill_inc = fill_q;
    end
  end

  // Next-state: config load wins over a coincident data bit
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    seq_d   = 1'b0;
    match   = 1'b0;
    unique case (1'b1)
      cfg_load: begin
        pat_d   = pattern;
        len_d   = len_clamp;
        ovl_d   = overlap_en;
        hist_d  = '0;
        fill_d  = '0;
        state_d = (len_clamp != '0) ? ARMED : UNCFG;
      end
      (!cfg_load && state_q == ARMED && in_valid): begin
        hist_d = {hist_q[MAX_LEN-2:0], in_bit};
        match  = (fill_inc >= len_q) &&
                 (((hist_d ^ pat_q) & mask) == '0);
        fill_d = (match && !ovl_q) ? '0 : fill_inc;
        seq_d  = match;
      end
      default: ;
    endcase
  end

  // State, configuration and history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNCFG;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      seq_q   <= seq_d;
    end
  end

  assign armed        = (state_q == ARMED);
  assign seq_detected = seq_q;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match count, cleared on reconfiguration
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = '0;
    end else if (match && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, in step with seq_detected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector.
// Queue-based bit-history model predicts pulses, counter and armed.
module tb_param_seq_detector;

  localparam int ML = 8;
  localparam int CW = 2;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_load;
  logic [ML-1:0] pattern;
  logic [LW-1:0] pat_len;
  logic          overlap_en;
  logic          in_valid;
  logic          in_bit;
  logic          armed;
  logic          seq_detected;
  logic [CW-1:0] match_count;

  param_seq_detector #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_load     (cfg_load),
    .pattern      (pattern),
    .pat_len      (pat_len),
    .overlap_en   (overlap_en),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .armed        (armed),
    .seq_detected (seq_detected),
    .match_count  (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic seq;
    int   cnt;
    logic arm;
  } exp_t;

  exp_t    sb[$];
  int      checks = 0;
  int      failures = 0;
  int      pulses = 0;

  bit      mq[$];
  logic [ML-1:0] mpat;
  int      mlen;
  bit      movl;
  bit      marm;
  int      mcnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpat = '0;
    mlen = 0;
    movl = 1'b0;
    marm = 1'b0;
    mcnt = 0;
  endtask

  task automatic step(input logic ld, input logic v,
                      input logic b);
    exp_t e;
    bit   hit;
    e.seq = 1'b0;
    if (ld) begin
      mpat = pattern;
      mlen = (int'(pat_len) > ML) ? ML : int'(pat_len);
      movl = overlap_en;
      marm = (mlen != 0);
      mq.delete();
      mcnt = 0;
    end else if (marm && v) begin
      mq.push_back(b);
      if (mq.size() > ML) void'(mq.pop_front());
      hit = (mq.size() >= mlen);
      for (int k = 0; k < mlen && hit; k++) begin
        if (mq[mq.size() - 1 - k] != mpat[k]) hit = 1'b0;
      end
      if (hit) begin
        e.seq = 1'b1;
        if (!movl) mq.delete();
`ifdef SEQDET_MATCH_COUNT_EN
        if (mcnt < (1 << CW) - 1) mcnt++;
`endif
      end
    end
    e.cnt = mcnt;
    e.arm = marm;
    sb.push_back(e);
    cfg_load = ld;
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    e = sb.pop_front();
    chk("seq", seq_detected, e.seq);
    chk("cnt", match_count, e.cnt);
    chk("armed", armed, e.arm);
    pulses += int'(seq_detected);
  endtask

  task automatic load(input logic [ML-1:0] p,
                      input logic [LW-1:0] l,
                      input logic o);
    pattern    = p;
    pat_len    = l;
    overlap_en = o;
    step(1'b1, 1'b0, 1'b0);
    pulses = 0;
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, bits[i]);
    end
  endtask

  task automatic npulse(input string tag, input int n);
    chk(tag, pulses, n);
    pulses = 0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_load = 1'b0;
    pattern = '0;
    pat_len = '0;
    overlap_en = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_armed", armed, 0);
    chk("rst_seq", seq_detected, 0);
    chk("rst_cnt", match_count, 0);
    rst = 1'b0;

    step(1'b0, 1'b1, 1'b1);
    npulse("uncfg_ignored", 0);

    load(8'b0000_1011, 4, 1'b1);
    stream(16'b1011011, 7);
    npulse("ovl_1011", 2);

    load(8'b0000_1011, 4, 1'b0);
    stream(16'b1011011, 7);
    npulse("novl_1011", 1);

    load(8'b0000_0011, 2, 1'b1);
    stream(16'hFF, 8);
    npulse("ovl_11", 7);

    load(8'b0000_0011, 2, 1'b0);
    stream(16'hFF, 8);
    npulse("novl_11", 4);

    load(8'b0000_0101, 3, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    npulse("gap_none", 0);
    step(1'b0, 1'b1, 1'b1);
    npulse("gap_101", 1);

    load(8'b0000_0001, 0, 1'b1);
    stream(16'b1011, 4);
    npulse("len0", 0);

    load(8'hCA, 12, 1'b1);
    stream(16'hCA, 8);
    npulse("clamp8", 1);

    pattern    = 8'b0000_0011;
    pat_len    = 2;
    overlap_en = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    pulses = 0;
    step(1'b0, 1'b1, 1'b1);
    npulse("ld_discard", 0);
    step(1'b0, 1'b1, 1'b1);
    npulse("ld_after", 1);

    load(8'b0000_1011, 4, 1'b1);
    stream(16'b101, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_armed", armed, 0);
    chk("arst_seq", seq_detected, 0);
    chk("arst_cnt", match_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    stream(16'b1011, 4);
    npulse("post_rst", 0);

    load(8'b0000_0001, 1, 1'b1);
    stream(16'b11111, 5);
    npulse("len1_sat", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
